trigger_ctrl: RTL and testbench
===============================

# trigger_ctrl

Parametrised acquisition trigger controller for the oscilloscope datapath. It watches the sampled ADC stream and detects rising, falling or either-edge threshold crossings with programmable hysteresis, plus an auto-trigger timeout. It sequences pre-trigger, post-trigger and holdoff windows and tells the sample buffer when to write. It sits between the ADC sample interface and the capture buffer/display logic.

## Interface
- DATA_W, 12, sample/threshold width (unsigned)
- CNT_W, 16, width of window/holdoff counters
- AUTO_TIMEOUT, 4096, samples in WAIT before a forced trigger in auto mode (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle start; honoured only in IDLE
- abort  in  1  return to IDLE from any state; beats arm
- continuous  in  1  after holdoff, re-arm automatically (else IDLE)
- sample_valid  in  1  qualifies data
- data  in  DATA_W  ADC sample
- mode  in  2  0 rise, 1 fall, 2 both, 3 auto (rise + timeout)
- threshold  in  DATA_W  trigger level
- hysteresis  in  DATA_W  re-arm band
- pre_count  in  CNT_W  samples captured before trigger is allowed
- post_count  in  CNT_W  samples captured after the triggering sample
- holdoff  in  CNT_W  clk cycles of dead time after done
- trig  out  1  1-cycle pulse, edge trigger
- forced  out  1  1-cycle pulse, auto-timeout trigger
- done  out  1  1-cycle pulse, post window complete
- capture_en  out  1  write strobe for capture buffer
- busy  out  1  state ≠ IDLE

## Operation
- mode, threshold, hysteresis, pre_count, post_count and holdoff are latched on arm and on each auto re-arm. Changes during a capture have no effect.
- Hysteresis comparator, computed at DATA_W+1 bits:
  - lo = max(threshold − hysteresis, 0); hi = min(threshold + hysteresis, 2^DATA_W − 1).
  - Rise flag sets on a valid sample ≤ lo. A rise edge is a valid sample ≥ threshold while the flag is set; the edge clears the flag.
  - Fall flag sets on a valid sample ≥ hi. A fall edge is a valid sample ≤ threshold while the flag is set; the edge clears the flag.
  - Both flags clear on entry to PRE.
- States:
  - IDLE: arm & !abort → PRE; sample counter cleared.
  - PRE: counts valid samples; flags are tracked. After pre_count samples → WAIT. pre_count = 0 → WAIT on the next cycle.
  - WAIT: on a valid sample with an enabled edge → POST, trig. Mode 3 counts valid samples and, at AUTO_TIMEOUT without an edge → POST, forced. An edge on the timeout sample gives trig, not forced.
  - POST: the triggering sample is post index 0 and is already captured. After post_count further valid samples → HOLD, done.
  - HOLD: counts holdoff clk cycles, then → PRE if continuous, else → IDLE. holdoff = 0 → exit on the next cycle.
- abort: synchronous, any state → IDLE, no pulses; beats arm in the same cycle.
- capture_en = sample_valid & state ∈ {PRE, WAIT, POST}, including the triggering sample.
- Counters saturate and never wrap. CNT_W must hold pre_count, post_count and AUTO_TIMEOUT.

## Timing
- Reset: state IDLE, counters and flags 0, trig/forced/done/busy = 0, capture_en = 0.
- trig/forced: registered, asserted the cycle after the clock edge that sampled the triggering data. Always exactly one cycle.
- done: asserted the cycle after the last post sample; HOLD entered on the same edge.
- busy: rises the cycle after arm and falls the cycle after the HOLD → IDLE transition.
- capture_en: combinational from the state register and sample_valid, so zero latency to the buffer.
- Reset asserted mid-capture: outputs go to reset values immediately; no done is issued.

## Structure
- Package trigger_pkg holds:
  - trig_state_t enum {IDLE, PRE, WAIT, POST, HOLD};
  - trig_mode_t enum {TRIG_RISE, TRIG_FALL, TRIG_BOTH, TRIG_AUTO};
  - localparam for the counter reset value.
- Sub-module trigger_edge_det: hysteresis comparator and the two arm flags. Inputs: clk, rst, clr, valid, data, threshold, hysteresis. Outputs: rise_edge, fall_edge.
- trigger_ctrl: FSM, counters, parameter latches.

## Test plan
- Rising, thr 2048, hyst 100, pre 4, post 8; ramp 1900→2100 step 50 after PRE → trig once on sample 2050; 9 capture_en in POST; done 8 valid samples after trig.
- Hysteresis noise: samples oscillate 2040/2060 after one crossing with no dip ≤ 1948 → no second trig in continuous mode. A dip to 1940 re-enables the trigger.
- Falling with thr 10, hyst 50 → lo saturates at 0; ramp 100→0 → trig at sample ≤ 10; mode both fires on either direction.
- Auto mode, AUTO_TIMEOUT 16, constant data 0 → forced pulse after the 16th WAIT sample, trig stays 0.
- continuous = 1, holdoff 5 → PRE re-entered exactly 5 cycles after HOLD entry. abort asserted in POST together with arm → IDLE, no done, busy low the next cycle.
- Async rst asserted in WAIT between clock edges → all outputs 0 immediately; arm after release runs a full capture.

Source files
------------

// File: rtl/trigger_pkg.sv
// trigger_pkg: shared types and constants for the acquisition trigger controller.
//   trig_state_t - controller FSM states
//   trig_mode_t  - trigger mode encoding as seen on the mode input
//   CNT_RST_VAL  - value loaded into the window/holdoff counter on (re)start
package trigger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        HOLD
    } trig_state_t;

    typedef enum logic [1:0] {
        TRIG_RISE,
        TRIG_FALL,
        TRIG_BOTH,
        TRIG_AUTO
    } trig_mode_t;

    localparam int unsigned CNT_RST_VAL = 0;

endpackage

// File: rtl/trigger_edge_det.sv
// trigger_edge_det: hysteresis threshold comparator with separate rise/fall arm flags.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   clr                    - synchronous clear of both arm flags
//   valid, data            - qualified ADC sample
//   threshold, hysteresis  - trigger level and re-arm band
//   rise_edge, fall_edge   - combinational edge indications for the current sample
module trigger_edge_det #(
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] hysteresis,
    output logic              rise_edge,
    output logic              fall_edge
);

    localparam logic [DATA_W:0] MAX_VAL = {1'b0, {DATA_W{1'b1}}};

    // One extra bit so threshold +/- hysteresis can be clamped instead of wrapping.
    logic [DATA_W:0] data_x;
    logic [DATA_W:0] thr_x;
    logic [DATA_W:0] hyst_x;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] lo;
    logic [DATA_W:0] hi;

    logic rise_flag_q;
    logic fall_flag_q;

    always_comb begin
        data_x = {1'b0, data};
        thr_x  = {1'b0, threshold};
        hyst_x = {1'b0, hysteresis};
        sum    = thr_x + hyst_x;
        lo     = (thr_x >= hyst_x) ? (thr_x - hyst_x) : '0;
        hi     = (sum > MAX_VAL) ? MAX_VAL : sum;
    end

    assign rise_edge = valid & rise_flag_q & (data_x >= thr_x);
    assign fall_edge = valid & fall_flag_q & (data_x <= thr_x);

    // An edge consumes its flag; the signal must go back beyond the band to re-arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_flag_q <= 1'b0;
            fall_flag_q <= 1'b0;
        end else if (clr) begin
            rise_flag_q <= 1'b0;
            fall_flag_q <= 1'b0;
        end else if (valid) begin
            if (rise_edge) begin
                rise_flag_q <= 1'b0;
            end else if (data_x <= lo) begin
                rise_flag_q <= 1'b1;
            end
            if (fall_edge) begin
                fall_flag_q <= 1'b0;
            end else if (data_x >= hi) begin
                fall_flag_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/trigger_ctrl.sv
// trigger_ctrl: acquisition trigger sequencer (pre / wait / post / holdoff).
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   arm, abort, continuous  - capture control
//   sample_valid, data      - ADC sample stream
//   mode, threshold, hysteresis, pre_count, post_count, holdoff
//                           - capture settings, latched on arm and on auto re-arm
//   trig, forced, done      - registered single-cycle event pulses
//   capture_en              - write strobe for the capture buffer (combinational)
//   busy                    - controller not idle
module trigger_ctrl
    import trigger_pkg::*;
#(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              continuous,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] hysteresis,
    input  logic [CNT_W-1:0]  pre_count,
    input  logic [CNT_W-1:0]  post_count,
    input  logic [CNT_W-1:0]  holdoff,
    output logic              trig,
    output logic              forced,
    output logic              done,
    output logic              capture_en,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_RST    = CNT_W'(CNT_RST_VAL);
    localparam logic [CNT_W-1:0] AUTO_LIMIT = CNT_W'(AUTO_TIMEOUT);

    trig_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    trig_mode_t        mode_q;
    logic [DATA_W-1:0] thr_q;
    logic [DATA_W-1:0] hyst_q;
    logic [CNT_W-1:0]  pre_q;
    logic [CNT_W-1:0]  post_q;
    logic [CNT_W-1:0]  hold_q;

    logic trig_q, trig_d;
    logic forced_q, forced_d;
    logic done_q, done_d;
    logic latch;
    logic edge_clr;
    logic edge_hit;
    logic rise_edge;
    logic fall_edge;

    trigger_edge_det #(
        .DATA_W(DATA_W)
    ) u_edge_det (
        .clk       (clk),
        .rst       (rst),
        .clr       (edge_clr),
        .valid     (sample_valid),
        .data      (data),
        .threshold (thr_q),
        .hysteresis(hyst_q),
        .rise_edge (rise_edge),
        .fall_edge (fall_edge)
    );

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        edge_hit = 1'b0;
        unique case (mode_q)
            TRIG_RISE, TRIG_AUTO: edge_hit = rise_edge;
            TRIG_FALL:            edge_hit = fall_edge;
            TRIG_BOTH:            edge_hit = rise_edge | fall_edge;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        trig_d   = 1'b0;
        forced_d = 1'b0;
        done_d   = 1'b0;
        latch    = 1'b0;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = CNT_RST;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d = PRE;
                        cnt_d   = CNT_RST;
                        latch   = 1'b1;
                    end
                end
                PRE: begin
                    if (pre_q == '0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_RST;
                    end else if (sample_valid) begin
                        if (cnt_inc >= pre_q) begin
                            state_d = WAIT;
                            cnt_d   = CNT_RST;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                WAIT: begin
                    // A real edge wins over the timeout on the same sample.
                    if (edge_hit) begin
                        state_d = POST;
                        cnt_d   = CNT_RST;
                        trig_d  = 1'b1;
                    end else if (sample_valid && mode_q == TRIG_AUTO) begin
                        if (cnt_inc >= AUTO_LIMIT) begin
                            state_d  = POST;
                            cnt_d    = CNT_RST;
                            forced_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                POST: begin
                    // The triggering sample was index 0; count the ones after it.
                    if (post_q == '0) begin
                        state_d = HOLD;
                        cnt_d   = CNT_RST;
                        done_d  = 1'b1;
                    end else if (sample_valid) begin
                        if (cnt_inc >= post_q) begin
                            state_d = HOLD;
                            cnt_d   = CNT_RST;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    // HOLD always lasts at least one cycle, so holdoff 0 and 1 match.
                    if (cnt_inc >= hold_q) begin
                        cnt_d = CNT_RST;
                        if (continuous) begin
                            state_d = PRE;
                            latch   = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_RST;
                end
            endcase
        end
    end

    assign edge_clr = (state_d == PRE) && (state_q != PRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_RST;
            trig_q   <= 1'b0;
            forced_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            trig_q   <= trig_d;
            forced_q <= forced_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= TRIG_RISE;
            thr_q  <= '0;
            hyst_q <= '0;
            pre_q  <= '0;
            post_q <= '0;
            hold_q <= '0;
        end else if (latch) begin
            mode_q <= trig_mode_t'(mode);
            thr_q  <= threshold;
            hyst_q <= hysteresis;
            pre_q  <= pre_count;
            post_q <= post_count;
            hold_q <= holdoff;
        end
    end

    assign trig       = trig_q;
    assign forced     = forced_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
    assign capture_en = sample_valid & ((state_q == PRE) | (state_q == WAIT) | (state_q == POST));

endmodule

// File: tb/tb_trigger_ctrl.sv
// tb_trigger_ctrl: directed self-checking bench for trigger_ctrl.
module tb_trigger_ctrl;
    import trigger_pkg::*;

    localparam int unsigned DATA_W       = 12;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned AUTO_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              abort;
    logic              continuous;
    logic              sample_valid;
    logic [DATA_W-1:0] data;
    logic [1:0]        mode;
    logic [DATA_W-1:0] threshold;
    logic [DATA_W-1:0] hysteresis;
    logic [CNT_W-1:0]  pre_count;
    logic [CNT_W-1:0]  post_count;
    logic [CNT_W-1:0]  holdoff;
    logic              trig;
    logic              forced;
    logic              done;
    logic              capture_en;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    logic cap_seen;
    int   cap_count;

    trigger_ctrl #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .abort       (abort),
        .continuous  (continuous),
        .sample_valid(sample_valid),
        .data        (data),
        .mode        (mode),
        .threshold   (threshold),
        .hysteresis  (hysteresis),
        .pre_count   (pre_count),
        .post_count  (post_count),
        .holdoff     (holdoff),
        .trig        (trig),
        .forced      (forced),
        .done        (done),
        .capture_en  (capture_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        sample_valid = 1'b1;
        data         = d;
        #1 cap_seen  = capture_en;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic configure(input trig_mode_t m, input int thr, input int hy, input int pre,
                             input int post, input int ho, input logic cont);
        mode       = m;
        threshold  = DATA_W'(thr);
        hysteresis = DATA_W'(hy);
        pre_count  = CNT_W'(pre);
        post_count = CNT_W'(post);
        holdoff    = CNT_W'(ho);
        continuous = cont;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] ramp_up [4];
        logic [DATA_W-1:0] ramp_dn [4];
        logic [DATA_W-1:0] noise [4];
        ramp_up = '{12'd1900, 12'd1950, 12'd2000, 12'd2050};
        ramp_dn = '{12'd80, 12'd50, 12'd30, 12'd10};
        noise   = '{12'd2060, 12'd2040, 12'd2060, 12'd2040};

        rst = 1'b1; arm = 1'b0; abort = 1'b0; sample_valid = 1'b1; data = '0;
        configure(TRIG_RISE, 0, 0, 0, 0, 0, 1'b0);
        #12;
        check_eq("reset_outputs", {27'd0, trig, forced, done, capture_en, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;
        tick();

        // Rising edge: thr 2048, hyst 100, pre 4, post 8, holdoff 3
        configure(TRIG_RISE, 2048, 100, 4, 8, 3, 1'b0);
        do_arm();
        check_eq("t1_busy_after_arm", busy, 1);
        for (int i = 0; i < 4; i++) begin
            send(12'd1900);
            check_eq("t1_pre_capture", cap_seen, 1);
        end
        for (int i = 0; i < 4; i++) begin
            send(ramp_up[i]);
            check_eq("t1_ramp_trig", trig, (i == 3) ? 1 : 0);
        end
        cap_count = int'(cap_seen);
        for (int i = 0; i < 8; i++) begin
            send(12'd2100);
            cap_count += int'(cap_seen);
            if (i == 0) check_eq("t1_trig_one_cycle", trig, 0);
            check_eq("t1_done", done, (i == 7) ? 1 : 0);
        end
        check_eq("t1_post_captures", cap_count, 9);
        sample_valid = 1'b1;
        #1 check_eq("t1_hold_no_capture", capture_en, 0);
        sample_valid = 1'b0;
        tick();
        tick();
        check_eq("t1_busy_in_hold", busy, 1);
        tick();
        check_eq("t1_busy_after_hold", busy, 0);

        // Hysteresis noise in continuous mode, holdoff 5
        configure(TRIG_RISE, 2048, 100, 1, 1, 5, 1'b1);
        do_arm();
        send(12'd1940);
        send(12'd2060);
        check_eq("t2_first_trig", trig, 1);
        send(12'd2040);
        check_eq("t2_done", done, 1);
        for (int i = 0; i < 4; i++) tick();
        sample_valid = 1'b1;
        #1 check_eq("t2_still_hold", capture_en, 0);
        sample_valid = 1'b0;
        tick();
        sample_valid = 1'b1;
        #1 check_eq("t2_pre_after_5", capture_en, 1);
        sample_valid = 1'b0;
        send(12'd2040);
        for (int i = 0; i < 4; i++) begin
            send(noise[i]);
            check_eq("t2_noise_no_trig", trig, 0);
        end
        send(12'd1940);
        check_eq("t2_dip_no_trig", trig, 0);
        send(12'd2060);
        check_eq("t2_rearm_trig", trig, 1);
        continuous = 1'b0;
        do_abort();
        check_eq("t2_abort_idle", busy, 0);

        // Falling edge, thr 10 hyst 50 (lo clamps to 0)
        configure(TRIG_FALL, 10, 50, 1, 1, 0, 1'b0);
        do_arm();
        send(12'd100);
        for (int i = 0; i < 4; i++) begin
            send(ramp_dn[i]);
            check_eq("t3_fall_trig", trig, (i == 3) ? 1 : 0);
        end
        send(12'd10);
        check_eq("t3_done", done, 1);
        tick();
        check_eq("t3_idle", busy, 0);

        configure(TRIG_RISE, 10, 50, 1, 1, 0, 1'b0);
        do_arm();
        send(12'd5);
        send(12'd20);
        check_eq("t3_lo_sat_no_trig", trig, 0);
        send(12'd0);
        send(12'd20);
        check_eq("t3_lo_sat_trig", trig, 1);
        do_abort();

        // Both edges, continuous with holdoff 0
        configure(TRIG_BOTH, 2048, 100, 1, 1, 0, 1'b1);
        do_arm();
        send(12'd1900);
        send(12'd2100);
        check_eq("t4_both_rise", trig, 1);
        send(12'd2100);
        check_eq("t4_done", done, 1);
        tick();
        send(12'd2200);
        send(12'd2000);
        check_eq("t4_both_fall", trig, 1);
        continuous = 1'b0;
        do_abort();

        // Auto timeout with constant 0, pre 0
        configure(TRIG_AUTO, 2048, 100, 0, 2, 0, 1'b0);
        do_arm();
        tick();
        for (int i = 0; i < 16; i++) begin
            send(12'd0);
            check_eq("t5_forced", forced, (i == 15) ? 1 : 0);
            check_eq("t5_no_trig", trig, 0);
        end
        send(12'd0);
        check_eq("t5_forced_one_cycle", forced, 0);
        send(12'd0);
        check_eq("t5_done", done, 1);
        tick();
        check_eq("t5_idle", busy, 0);

        // Edge on the timeout sample gives trig, not forced
        do_arm();
        tick();
        for (int i = 0; i < 15; i++) send(12'd0);
        send(12'd2100);
        check_eq("t5_edge_wins_trig", trig, 1);
        check_eq("t5_edge_wins_forced", forced, 0);
        do_abort();

        // abort together with arm in POST
        configure(TRIG_RISE, 2048, 100, 1, 4, 0, 1'b0);
        do_arm();
        send(12'd1900);
        send(12'd2100);
        check_eq("t6_trig", trig, 1);
        send(12'd2100);
        abort = 1'b1;
        arm   = 1'b1;
        send(12'd2100);
        abort = 1'b0;
        arm   = 1'b0;
        check_eq("t6_abort_busy", busy, 0);
        check_eq("t6_abort_no_done", done, 0);
        tick();
        check_eq("t6_stay_idle", busy, 0);

        // Asynchronous reset while in WAIT
        configure(TRIG_RISE, 2048, 100, 1, 2, 0, 1'b0);
        do_arm();
        send(12'd1900);
        sample_valid = 1'b1;
        data = 12'd1000;
        #1 check_eq("t7_wait_capture", capture_en, 1);
        #1 rst = 1'b1;
        #1 check_eq("t7_async_outputs", {27'd0, trig, forced, done, capture_en, busy}, 0);
        sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_arm();
        send(12'd1900);
        send(12'd2100);
        check_eq("t7_after_rst_trig", trig, 1);
        send(12'd2100);
        send(12'd2100);
        check_eq("t7_after_rst_done", done, 1);
        tick();
        check_eq("t7_after_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
